lm_sm_sequencer: RTL and testbench

- Decode-side block directly downstream of the fetch stage, reading the IF/ID instruction register.
- Expands each multiple-transfer instruction (LM opcode 0110, SM opcode 0111) into one single-register LW/SW micro-op per cycle.
- While expanding, it holds the PC and drives the fetch stage's IR write-select mux so IF/ID is reloaded with the shrinking LM/SM word.
- All other instructions pass through unchanged.

---
 rtl/lm_sm_sequencer_pkg.sv | 31 +++
 rtl/lm_sm_sequencer_priority_pick8.sv | 36 +++
 rtl/lm_sm_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: opcodes, ISA field
// positions, FSM encoding and a bitmap popcount helper.
package lm_sm_sequencer_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 9;
    localparam int BMP_MSB = 7;
    localparam int BMP_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_priority_pick8.sv
// Chooses the next register of an LM/SM bitmap: ascending order, except that an
// LM defers its own base register until it is the only one left.
module priority_pick8
    import lm_sm_sequencer_pkg::*;
(
    input  logic [7:0] rem,
    input  logic [7:0] orig,
    input  logic [2:0] ra,
    input  logic       is_lm,
    output logic [2:0] idx,
    output logic [3:0] rank,
    output logic [7:0] clr_mask,
    output logic       last
);

    logic [7:0] ra_bit_s;
    logic [7:0] cand_s;
    logic [7:0] onehot_s;

    // Candidate set, lowest-bit isolation, encode, rank and last detection.
    always_comb begin
        ra_bit_s = 8'd1 << ra;
        if (is_lm && ((rem & ra_bit_s) != 8'h00) && ((rem & ~ra_bit_s) != 8'h00)) begin
            cand_s = rem & ~ra_bit_s;
        end else begin
            cand_s = rem;
        end
        onehot_s = cand_s & (~cand_s + 8'd1);
        idx      = {|(onehot_s & 8'hF0), |(onehot_s & 8'hCC), |(onehot_s & 8'hAA)};
        // Rank is taken against the original list so a deferred base keeps its slot.
        rank     = popcount8(orig & (onehot_s - 8'd1));
        clr_mask = onehot_s;
        last     = ((rem & ~onehot_s) == 8'h00);
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM instructions from IF/ID into one LW/SW micro-op per cycle,
// holding the PC and reloading IF/ID with the shrinking word meanwhile.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_in,
    input  logic        ir_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] uop_IR,
    output logic        uop_valid,
    output logic [15:0] new_IR_multi,
    output logic        IR_load_mux,
    output logic        PCWrite,
    output logic        busy
);

    seq_state_e  state_r;
    logic [3:0]  op_r;
    logic [2:0]  ra_r;
    logic [7:0]  orig_r;
    logic [7:0]  rem_r;

    seq_state_e  next_state_s;
    logic [3:0]  op_nxt_s;
    logic [2:0]  ra_nxt_s;
    logic [7:0]  orig_nxt_s;
    logic [7:0]  rem_nxt_s;

    logic [3:0]  op_src_s;
    logic [2:0]  ra_src_s;
    logic [7:0]  orig_src_s;
    logic [7:0]  rem_src_s;
    logic        is_lm_s;
    logic        in_multi_s;

    logic [2:0]  pick_idx_s;
    logic [3:0]  pick_rank_s;
    logic [7:0]  pick_clr_s;
    logic        pick_last_s;
    logic [7:0]  rem_after_s;
    logic [15:0] uop_word_s;
    logic [15:0] multi_word_s;

    logic [15:0] uop_ir_s;
    logic        uop_valid_s;
    logic [15:0] new_ir_s;
    logic        load_mux_s;
    logic        pc_write_s;

    // Operand source: live IF/ID word when idle, captured copy while sequencing.
    always_comb begin
        if (state_r == ST_SEQ) begin
            op_src_s   = op_r;
            ra_src_s   = ra_r;
            orig_src_s = orig_r;
            rem_src_s  = rem_r;
        end else begin
            op_src_s   = ir_in[OPC_MSB:OPC_LSB];
            ra_src_s   = ir_in[RA_MSB:RA_LSB];
            orig_src_s = ir_in[BMP_MSB:BMP_LSB];
            rem_src_s  = ir_in[BMP_MSB:BMP_LSB];
        end
        is_lm_s    = (op_src_s == OP_LM);
        in_multi_s = ir_valid && ((ir_in[OPC_MSB:OPC_LSB] == OP_LM) ||
                                  (ir_in[OPC_MSB:OPC_LSB] == OP_SM));
    end

    priority_pick8 u_pick (
        .rem      (rem_src_s),
        .orig     (orig_src_s),
        .ra       (ra_src_s),
        .is_lm    (is_lm_s),
        .idx      (pick_idx_s),
        .rank     (pick_rank_s),
        .clr_mask (pick_clr_s),
        .last     (pick_last_s)
    );

    assign rem_after_s  = rem_src_s & ~pick_clr_s;
    assign uop_word_s   = {(is_lm_s ? OP_LW : OP_SW), pick_idx_s, ra_src_s, 2'b00, pick_rank_s};
    assign multi_word_s = {op_src_s, ra_src_s, 1'b0, rem_after_s};

    // Next-state and unqualified outputs.
    always_comb begin
        next_state_s = state_r;
        op_nxt_s     = 4'd0;
        ra_nxt_s     = 3'd0;
        orig_nxt_s   = 8'd0;
        rem_nxt_s    = 8'd0;
        uop_ir_s     = ir_in;
        uop_valid_s  = ir_valid;
        new_ir_s     = 16'h0000;
        load_mux_s   = 1'b0;
        pc_write_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (in_multi_s) begin
                    if (rem_src_s != 8'h00) begin
                        uop_ir_s    = uop_word_s;
                        uop_valid_s = 1'b1;
                        new_ir_s    = multi_word_s;
                        if (!pick_last_s) begin
                            next_state_s = ST_SEQ;
                            load_mux_s   = 1'b1;
                            pc_write_s   = 1'b0;
                            op_nxt_s     = op_src_s;
                            ra_nxt_s     = ra_src_s;
                            orig_nxt_s   = orig_src_s;
                            rem_nxt_s    = rem_after_s;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end else begin
                        uop_valid_s = 1'b0;
                    end
                end else begin
                    uop_ir_s    = ir_in;
                    uop_valid_s = ir_valid;
                end
            end
            ST_SEQ: begin
                uop_ir_s    = uop_word_s;
                uop_valid_s = 1'b1;
                new_ir_s    = multi_word_s;
                if (pick_last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    load_mux_s = 1'b1;
                    pc_write_s = 1'b0;
                    op_nxt_s   = op_r;
                    ra_nxt_s   = ra_r;
                    orig_nxt_s = orig_r;
                    rem_nxt_s  = rem_after_s;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Reset, flush and stall qualification of the outputs.
    always_comb begin
        uop_IR       = uop_ir_s;
        uop_valid    = uop_valid_s;
        new_IR_multi = new_ir_s;
        IR_load_mux  = load_mux_s;
        PCWrite      = pc_write_s;
        busy         = (state_r == ST_SEQ);
        if (reset) begin
            uop_IR       = 16'h0000;
            uop_valid    = 1'b0;
            new_IR_multi = 16'h0000;
            IR_load_mux  = 1'b0;
            PCWrite      = 1'b1;
            busy         = 1'b0;
        end else if (flush) begin
            uop_valid   = 1'b0;
            IR_load_mux = 1'b0;
            PCWrite     = 1'b1;
        end else if (stall) begin
            PCWrite = 1'b0;
        end else begin
            PCWrite = pc_write_s;
        end
    end

    // State and captured-instruction registers.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            ra_r    <= 3'd0;
            orig_r  <= 8'd0;
            rem_r   <= 8'd0;
        end else if (!stall) begin
            state_r <= next_state_s;
            op_r    <= op_nxt_s;
            ra_r    <= ra_nxt_s;
            orig_r  <= orig_nxt_s;
            rem_r   <= rem_nxt_s;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: hand-computed micro-op words per cycle.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] ir_in;
    logic        ir_valid;
    logic        stall;
    logic        flush;
    logic [15:0] uop_IR;
    logic        uop_valid;
    logic [15:0] new_IR_multi;
    logic        IR_load_mux;
    logic        PCWrite;
    logic        busy;

    int n_checks;
    int n_fail;
    logic [35:0] obs;
    logic [35:0] exp_v;

    lm_sm_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .ir_in        (ir_in),
        .ir_valid     (ir_valid),
        .stall        (stall),
        .flush        (flush),
        .uop_IR       (uop_IR),
        .uop_valid    (uop_valid),
        .new_IR_multi (new_IR_multi),
        .IR_load_mux  (IR_load_mux),
        .PCWrite      (PCWrite),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {uop_IR, uop_valid, new_IR_multi, IR_load_mux, PCWrite, busy};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        next_cycle();
        ir_in    = 16'h0000;
        ir_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ir_in = 16'h1234; ir_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_v = {16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_values: got %h required %h", obs, exp_v); end
        next_cycle();
        reset = 1'b0; ir_in = 16'h0000; ir_valid = 1'b0;
    endtask

    task automatic test_lm_basic();
        next_cycle();
        ir_in = 16'h6429; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h4080, 1'b1, 16'h6428, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_basic_r0: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h4681, 1'b1, 16'h6420, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_basic_r3: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h4A82, 1'b1, 16'h6400, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_basic_r5: got %h required %h", obs, exp_v); end
        go_idle();
        @(negedge clk);
        exp_v = {16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_basic_done: got %h required %h", obs, exp_v); end
    endtask

    task automatic test_lm_defer();
        next_cycle();
        ir_in = 16'h6206; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h4441, 1'b1, 16'h6202, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_defer_r2: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h4240, 1'b1, 16'h6200, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lm_defer_r1: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    task automatic test_sm();
        next_cycle();
        ir_in = 16'h7681; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h50C0, 1'b1, 16'h7680, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sm_r0: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h5EC1, 1'b1, 16'h7600, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sm_r7: got %h required %h", obs, exp_v); end
        // SM whose base is in the list keeps plain ascending order
        next_cycle();
        ir_in = 16'h7206; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h5240, 1'b1, 16'h7204, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sm_nodefer_r1: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h5441, 1'b1, 16'h7200, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL sm_nodefer_r2: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    task automatic test_single();
        next_cycle();
        ir_in = 16'h6410; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h4880, 1'b1, 16'h6400, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL single_r4: got %h required %h", obs, exp_v); end
        next_cycle();
        ir_in = 16'h1234; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL single_after: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    task automatic test_empty();
        next_cycle();
        ir_in = 16'h6400; ir_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({uop_valid, IR_load_mux, PCWrite, busy} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_lm: got v/mux/pc/busy=%b%b%b%b required 0010", uop_valid, IR_load_mux, PCWrite, busy);
        end
        next_cycle();
        ir_in = 16'h1234; ir_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({uop_IR, uop_valid, PCWrite, busy} !== {16'h1234, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_pass: got uop=%h v=%b pc=%b busy=%b required uop=1234 v=1 pc=1 busy=0", uop_IR, uop_valid, PCWrite, busy);
        end
        go_idle();
    endtask

    task automatic test_stall();
        next_cycle();
        ir_in = 16'h6429; ir_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({uop_IR, PCWrite} !== {16'h4080, 1'b0}) begin
            n_fail++; $display("FAIL stall_first: got uop=%h pc=%b required uop=4080 pc=0", uop_IR, PCWrite);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            stall = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({uop_IR, PCWrite, busy} !== {16'h4681, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold%0d: got uop=%h pc=%b busy=%b required uop=4681 pc=0 busy=1", i, uop_IR, PCWrite, busy);
            end
        end
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        exp_v = {16'h4681, 1'b1, 16'h6420, 1'b1, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stall_resume: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h4A82, 1'b1, 16'h6400, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL stall_last: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    task automatic test_flush();
        next_cycle();
        ir_in = 16'h6429; ir_valid = 1'b1;
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({uop_valid, IR_load_mux, PCWrite} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL flush_cycle: got v/mux/pc=%b%b%b required 001", uop_valid, IR_load_mux, PCWrite);
        end
        next_cycle();
        flush = 1'b0; ir_in = 16'h1234; ir_valid = 1'b1;
        @(negedge clk);
        exp_v = {16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL flush_after: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        ir_in = 16'h6429; ir_valid = 1'b1;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        exp_v = {16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_during: got %h required %h", obs, exp_v); end
        next_cycle();
        reset = 1'b0; ir_in = 16'h0000; ir_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_after: got %h required %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        ir_in = 16'h6206; ir_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (uop_IR !== 16'h4441) begin n_fail++; $display("FAIL b2b_lm0: got %h required 4441", uop_IR); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({uop_IR, PCWrite} !== {16'h4240, 1'b1}) begin n_fail++; $display("FAIL b2b_lm1: got uop=%h pc=%b required uop=4240 pc=1", uop_IR, PCWrite); end
        next_cycle();
        ir_in = 16'h7681;
        @(negedge clk);
        exp_v = {16'h50C0, 1'b1, 16'h7680, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_sm0: got %h required %h", obs, exp_v); end
        next_cycle();
        @(negedge clk);
        exp_v = {16'h5EC1, 1'b1, 16'h7600, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_sm1: got %h required %h", obs, exp_v); end
        go_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lm_basic();
        test_lm_defer();
        test_sm();
        test_single();
        test_empty();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
